// File: rtl/upcount_ctrl.sv
// upcount_ctrl
// Sequencing controller for a CW-bit loadable up-counter (upcount). It drives
// the counter's load value (R), load strobe (L) and count enable (E). It also
// watches the counter output Q, so a run stops exactly at a programmed limit.
//
// A run starts with a Start command in IDLE. The block loads the captured
// Init value for one cycle (LOAD), then counts (RUN) until Q equals the
// captured Limit. At that point it either returns to IDLE or reloads and
// repeats, depending on the captured Auto flag. Stop aborts a run at any time.
//
// Ports:
//   clk_i      rising-edge clock, shared with the counter
//   rst_i      asynchronous active-high reset
//   start_i    begin a run (honoured only in IDLE, and only without stop_i)
//   stop_i     synchronous abort, honoured in any state
//   auto_i     1 = reload and repeat at the limit, 0 = single period
//   init_i     counter start value, captured with start_i
//   limit_i    terminal counter value, captured with start_i
//   q_i        counter output fed back from upcount
//   r_o        load value to upcount (the captured Init)
//   l_o        load strobe to upcount
//   e_o        count enable to upcount (combinational on state and q_i)
//   busy_o     registered, high whenever the controller is not IDLE
//   done_o     registered one-cycle pulse after each completed period
//   periods_o  completed periods since the last accepted start, saturating

module upcount_ctrl #(
  parameter int CW = 4,
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          auto_i,
  input  logic [CW-1:0] init_i,
  input  logic [CW-1:0] limit_i,
  input  logic [CW-1:0] q_i,
  output logic [CW-1:0] r_o,
  output logic          l_o,
  output logic          e_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [PW-1:0] periods_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_q,   state_d;
  logic [CW-1:0] init_q,    init_d;
  logic [CW-1:0] limit_q,   limit_d;
  logic          auto_q,    auto_d;
  logic [PW-1:0] periods_q, periods_d;
  logic          done_q,    done_d;
  logic          busy_q,    busy_d;
  logic          load_q,    load_d;

  logic          atLimit;
  logic          periodsFull;

  assign atLimit     = (q_i == limit_q);
  assign periodsFull = (periods_q == {PW{1'b1}});

  // State and captured-configuration registers. Busy and the load strobe are
  // registered copies of the next-state decode, so neither glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      init_q    <= '0;
      limit_q   <= '0;
      auto_q    <= 1'b0;
      periods_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      limit_q   <= limit_d;
      auto_q    <= auto_d;
      periods_q <= periods_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
    end
  end

  // Next-state logic. Stop is tested before the terminal condition, so an
  // aborted period never reports Done or bumps the period count.
  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    limit_d   = limit_q;
    auto_d    = auto_q;
    periods_d = periods_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          init_d    = init_i;
          limit_d   = limit_i;
          auto_d    = auto_i;
          periods_d = '0;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (atLimit) begin
          if (!periodsFull) begin
            periods_d = periods_q + {{(PW-1){1'b0}}, 1'b1};
          end
          done_d  = 1'b1;
          state_d = auto_q ? LOAD : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    load_d = (state_d == LOAD);
  end

  // The enable drops in the same cycle Q reaches the limit, so the counter
  // parks on the limit and never overshoots it.
  assign e_o       = (state_q == RUN) && !atLimit;
  assign l_o       = load_q;
  assign r_o       = init_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign periods_o = periods_q;

endmodule

// File: tb/tb_upcount_ctrl.sv
// tb_upcount_ctrl
// Self-checking bench for upcount_ctrl. A behavioural 4-bit loadable up-counter
// closes the R/L/E -> Q loop. The expected outputs come from a period-level
// model. That model tracks which cycle of a period it is in: position 0 is the
// load cycle, positions 1..N are the run cycles. It then derives every output
// from plain arithmetic on the captured Init/Limit.

module tb_upcount_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       autoMode;
  logic [3:0] init;
  logic [3:0] limit;
  logic [3:0] count;
  logic [3:0] rOut;
  logic       lOut;
  logic       eOut;
  logic       busyOut;
  logic       doneOut;
  logic [7:0] periodsOut;

  int tests;
  int failures;

  // Model state: the captured configuration plus the position within a period.
  int mActive;
  int mPos;
  int mInit;
  int mLimit;
  int mAuto;
  int mPeriods;
  int mDone;
  int mQ;

  typedef struct {
    logic       start;
    logic       stop;
    logic       autoMode;
    logic [3:0] init;
    logic [3:0] limit;
    logic       expL;
    logic       expE;
    logic [3:0] expQ;
    logic [3:0] expR;
    logic       expBusy;
    logic       expDone;
    logic [7:0] expPeriods;
  } vec_t;

  vec_t vecs[7];

  upcount_ctrl #(.CW(4), .PW(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .stop_i    (stop),
    .auto_i    (autoMode),
    .init_i    (init),
    .limit_i   (limit),
    .q_i       (count),
    .r_o       (rOut),
    .l_o       (lOut),
    .e_o       (eOut),
    .busy_o    (busyOut),
    .done_o    (doneOut),
    .periods_o (periodsOut)
  );

  // The attached counter: load has priority over enable, and it wraps modulo 16.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (lOut) begin
      count <= rOut;
    end else if (eOut) begin
      count <= count + 4'd1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int periodLen();
    return ((mLimit - mInit) & 15) + 1;
  endfunction

  task automatic modelReset();
    mActive  = 0;
    mPos     = 0;
    mInit    = 0;
    mLimit   = 0;
    mAuto    = 0;
    mPeriods = 0;
    mDone    = 0;
    mQ       = 0;
  endtask

  // Advances the model across one clock edge, using the inputs applied to it.
  task automatic modelEdge(input logic st, input logic sp, input logic au,
                           input logic [3:0] in, input logic [3:0] li);
    int n;
    n = periodLen();
    if (mActive != 0) begin
      // Leaving position p < N, the counter ends at Init + p.
      // It does so even when the cycle is aborted.
      if (mPos < n) mQ = (mInit + mPos) & 15;
      if (sp) begin
        mActive = 0;
        mDone   = 0;
      end else if (mPos == n) begin
        if (mPeriods < 255) mPeriods++;
        mDone   = 1;
        mPos    = 0;
        mActive = mAuto;
      end else begin
        mPos++;
        mDone = 0;
      end
    end else begin
      mDone = 0;
      if (st && !sp) begin
        mInit    = in;
        mLimit   = li;
        mAuto    = au;
        mPeriods = 0;
        mActive  = 1;
        mPos     = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic au,
                               input logic [3:0] in, input logic [3:0] li);
    start    = st;
    stop     = sp;
    autoMode = au;
    init     = in;
    limit    = li;
    @(posedge clk);
    modelEdge(st, sp, au, in, li);
    #1;
  endtask

  task automatic checkOutput();
    int n;
    n = periodLen();
    check("L",       lOut,       (mActive != 0 && mPos == 0) ? 1 : 0);
    check("E",       eOut,       (mActive != 0 && mPos >= 1 && mPos < n) ? 1 : 0);
    check("Q",       count,      mQ);
    check("R",       rOut,       mInit);
    check("Busy",    busyOut,    mActive);
    check("Done",    doneOut,    mDone);
    check("Periods", periodsOut, mPeriods);
  endtask

  task automatic idleOut();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    checkOutput();
  endtask

  initial begin
    int budget;
    int doneCount;
    tests    = 0;
    failures = 0;
    start    = 1'b0;
    stop     = 1'b0;
    autoMode = 1'b0;
    init     = 4'd0;
    limit    = 4'd0;
    rst      = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("resetBusy",    busyOut,    0);
    check("resetL",       lOut,       0);
    check("resetE",       eOut,       0);
    check("resetR",       rOut,       0);
    check("resetDone",    doneOut,    0);
    check("resetPeriods", periodsOut, 0);
    rst = 1'b0;

    // Single period: Init=2, Limit=5, Auto=0.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 1'b1, 4'd3, 4'd2, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 1'b1, 4'd4, 4'd2, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 1'b0, 4'd5, 4'd2, 1'b1, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0, 1'b1, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0, 1'b0, 8'd1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].autoMode, vecs[i].init, vecs[i].limit);
      check($sformatf("vec%0d.L", i),       lOut,       vecs[i].expL);
      check($sformatf("vec%0d.E", i),       eOut,       vecs[i].expE);
      check($sformatf("vec%0d.Q", i),       count,      vecs[i].expQ);
      check($sformatf("vec%0d.R", i),       rOut,       vecs[i].expR);
      check($sformatf("vec%0d.Busy", i),    busyOut,    vecs[i].expBusy);
      check($sformatf("vec%0d.Done", i),    doneOut,    vecs[i].expDone);
      check($sformatf("vec%0d.Periods", i), periodsOut, vecs[i].expPeriods);
    end

    // Wrap plus auto-reload: 14,15,0,1 then reload, with a 5-cycle period.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd14, 4'd1);
    checkOutput();
    doneCount = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      checkOutput();
      if (doneOut) doneCount++;
    end
    check("wrapPeriods", periodsOut, 3);
    check("wrapDones",   doneCount,  3);
    idleOut();

    // Equal bounds with saturation of the period count.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 4'd7);
    checkOutput();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd7, 4'd7);
      checkOutput();
    end
    check("satPeriods", periodsOut, 255);
    check("satQ",       count,      7);
    idleOut();

    // Stop on the same edge that sees Q == Limit.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd3);
    checkOutput();
    budget = 0;
    while (count != 4'd3 && budget < 10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
      checkOutput();
      budget++;
    end
    check("stopReachLimit", count, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd3);
    checkOutput();
    check("stopBusy",    busyOut,    0);
    check("stopDone",    doneOut,    0);
    check("stopPeriods", periodsOut, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
    check("stopDoneLater", doneOut, 0);

    // Start and a Limit change mid-run are ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd4);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd4);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd9);
    checkOutput();
    budget = 0;
    while (busyOut && budget < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd9);
      checkOutput();
      budget++;
    end
    check("ignoreEndQ",    count,      4);
    check("ignorePeriods", periodsOut, 1);
    check("ignoreDone",    doneOut,    1);
    // Start together with Stop in IDLE leaves everything alone.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 4'd8);
    checkOutput();
    check("startStopBusy",    busyOut,    0);
    check("startStopL",       lOut,       0);
    check("startStopPeriods", periodsOut, 1);

    // Asynchronous reset between edges, during the second period.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd1, 4'd12);
    checkOutput();
    budget = 0;
    while (!(count == 4'd6 && periodsOut != 8'd0) && budget < 40) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 4'd12);
      checkOutput();
      budget++;
    end
    check("arstReachQ6", count, 6);
    check("arstPeriodsBefore", periodsOut, 1);
    #2 rst = 1'b1;
    #1;
    check("arstE",       eOut,       0);
    check("arstL",       lOut,       0);
    check("arstBusy",    busyOut,    0);
    check("arstDone",    doneOut,    0);
    check("arstPeriods", periodsOut, 0);
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 4'd6);
    checkOutput();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      checkOutput();
    end
    check("arstRestartPeriods", periodsOut, 1);

    // Randomised traffic against the period model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
      checkOutput();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/upcount_ctrl.md
Name: upcount_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 4-bit loadable up-counter (upcount) and drives its R, L and E inputs.
- On a start command it loads a start value, enables counting, and watches the counter's Q. It stops counting exactly at a programmed limit, then either halts or reloads automatically.
- Reports busy status, a per-period done pulse and a saturating period count for downstream status logic.

Parameters:
- CW, 4, counter width; must match the attached upcount.
- PW, 8, width of the Periods counter.

Ports:
- Clock  in  1  rising-edge clock, shared with upcount.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin a run; sampled on a clock edge; honoured only in IDLE.
- Stop  in  1  synchronous abort; honoured in any state.
- Auto  in  1  1 = reload and repeat at the limit; 0 = single period. Captured with Start.
- Init  in  CW  counter start value. Captured with Start.
- Limit  in  CW  terminal value. Captured with Start.
- Q  in  CW  counter output, fed back from upcount.
- R  out  CW  load value to upcount; always equals captured Init.
- L  out  1  load strobe to upcount.
- E  out  1  count enable to upcount.
- Busy  out  1  high when state is not IDLE.
- Done  out  1  registered one-cycle pulse after each completed period.
- Periods  out  PW  completed periods since the last accepted Start; saturates at all-ones.

Behaviour:
- Counter contract: on each rising Clock edge, L=1 loads R into Q; otherwise E=1 increments Q modulo 2^CW. L has priority over E.
- Reset (async, active-high) forces: state=IDLE, captured Init/Limit/Auto=0, R=0, L=0, E=0, Busy=0, Done=0, Periods=0.
- Reset asserted mid-run takes effect immediately, without waiting for a clock edge.
- State IDLE: L=0, E=0.
  - Start=1 and Stop=0 at an edge: capture Init, Limit and Auto; clear Periods; go to LOAD.
- State LOAD: L=1, E=0, for exactly one cycle.
  - Next edge: go to RUN. The counter now holds Q=Init.
- State RUN: L=0. E is combinational: E = (Q != Limit).
  - The counter therefore never overshoots Limit.
- Terminal condition: state is RUN and Q == Limit, seen at an edge. At that edge:
  - Periods increments, holding at 2^PW-1 once reached.
  - Done=1 for the following cycle.
  - Next state is LOAD if Auto=1, otherwise IDLE.
- Period length: the number of RUN cycles is ((Limit - Init) mod 2^CW) + 1.
  - Limit < Init wraps through 15→0. Example: Init=14, Limit=1 counts 14, 15, 0, 1.
  - Limit == Init gives exactly one RUN cycle.
- Stop=1 at an edge, from LOAD or RUN: go to IDLE.
  - Stop has priority over the terminal condition: no Done, no Periods increment.
  - Periods keeps its value.
  - Q is left wherever the counter stopped.
- Start while in LOAD or RUN is ignored. Changes to Init, Limit or Auto mid-run are ignored (the captured copies are used).
- Start and Stop together in IDLE: stay in IDLE, nothing is captured, Periods is unchanged.
- Busy and Done are registered. E is the only combinational output; it depends on state and Q.

Test Plan:
- Bench instantiates upcount with R, L, E and Q wired to this block.
- Single period: Init=2, Limit=5, Auto=0, 1-cycle Start pulse -> one cycle L=1 with R=2; then Q=2,3,4,5 with E high for 3 cycles and low at Q=5; Done pulses once; Periods=1; Busy falls with Done; Q holds 5.
- Wrap plus auto-reload: Init=14, Limit=1, Auto=1 -> Q sequence 14,15,0,1 then reload to 14, repeating with a 5-cycle period; Done pulses every 5 cycles; Periods=3 after 15 cycles of run.
- Equal bounds and saturation (PW=8): Init=Limit=7, Auto=1 for 600 cycles -> Q stays 7; Done every 2 cycles; Periods reaches 255 and holds.
- Stop versus terminal: Init=0, Limit=3, Auto=0; assert Stop on the same edge Q==3 is seen -> IDLE next cycle, no Done, Periods=0.
- Ignored inputs: during RUN, pulse Start and change Limit to 9 -> run still ends at the original Limit. In IDLE, Start and Stop together -> stays IDLE with Periods unchanged.
- Async reset mid-run: Init=1, Limit=12, Reset pulsed between edges while Q=6 -> E, L, Busy, Done and Periods go to 0 immediately; after release, a new Start works normally.
